transducer_fire_sequencer: RTL and testbench

Sequences a bank of NCH transducer output channels through one or more fire events. It holds the per-channel phase-delay / charge-time / mask table and drives the shared channel control lines: channel reset, mark, go. It waits for every channel's fire-complete, spaces repeated pulses by a programmable repetition interval, and latches channel warnings into a sticky fault. It sits between the host register interface and the transducer output channel instances.

---
 rtl/transducer_fire_sequencer_pkg.sv | 25 ++
 rtl/transducer_fire_sequencer_table.sv | 39 +++
 rtl/transducer_fire_sequencer.sv | 165 ++++++++++++++++
 tb/tb_transducer_fire_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/transducer_fire_sequencer_pkg.sv
// Shared state encoding, default widths and watchdog limit for the transducer fire sequencer.
package transducer_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM1  = 3'd1,
    ST_ARM2  = 3'd2,
    ST_FIRE  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_GAP   = 3'd5,
    ST_FAULT = 3'd6
  } seqState_e;

  localparam int NCH_DEF  = 8;
  localparam int PD_W_DEF = 16;
  localparam int CT_W_DEF = 9;

  // Longest legitimate WAIT: full phase delay plus full charge time plus slack.
  function automatic int fireWdLimit(input int pdW, input int ctW);
    return int'((32'd1 << pdW) + (32'd1 << ctW) + 32'd8);
  endfunction

  localparam int WD_LIMIT = fireWdLimit(PD_W_DEF, CT_W_DEF);

endpackage

// File: rtl/transducer_fire_sequencer_table.sv
// Per-channel phase-delay / charge-time / mask table with a single write port
// and flattened outputs (channel i at [i*W +: W]).
module fire_table_regs
  import transducer_seq_pkg::*;
#(
  parameter int NCH  = NCH_DEF,
  parameter int PD_W = PD_W_DEF,
  parameter int CT_W = CT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wrEn,
  input  logic [$clog2(NCH)-1:0]  wrCh,
  input  logic [PD_W-1:0]         wrPd,
  input  logic [CT_W-1:0]         wrCt,
  input  logic                    wrMask,
  output logic [NCH*PD_W-1:0]     phaseDelay,
  output logic [NCH*CT_W-1:0]     chargeTime,
  output logic [NCH-1:0]          mask
);

  // Table storage; only the addressed channel slice is updated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phaseDelay <= {(NCH*PD_W){1'b0}};
      chargeTime <= {(NCH*CT_W){1'b0}};
      mask       <= {NCH{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wrEn && (int'(wrCh) == i)) begin
          phaseDelay[i*PD_W +: PD_W] <= wrPd;
          chargeTime[i*CT_W +: CT_W] <= wrCt;
          mask[i]                    <= wrMask;
        end
      end
    end
  end

endmodule

// File: rtl/transducer_fire_sequencer.sv
// Fire sequencer: drives shared channel reset/mark/go through bursts of pulses.
// Optional FIRE_WATCHDOG_EN adds a WAIT-state watchdog that forces FAULT.
module transducer_fire_sequencer
  import transducer_seq_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int PD_W  = PD_W_DEF,
  parameter int CT_W  = CT_W_DEF,
  parameter int PRI_W = 24,
  parameter int NP_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_wr,
  input  logic [$clog2(NCH)-1:0]  cfg_ch,
  input  logic [PD_W-1:0]         cfg_pd,
  input  logic [CT_W-1:0]         cfg_ct,
  input  logic                    cfg_mask,
  output logic                    cfg_rej,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    clear_fault,
  input  logic [NP_W-1:0]         num_pulses,
  input  logic [PRI_W-1:0]        pri,
  output logic                    ch_rst,
  output logic                    ch_mark,
  output logic                    ch_go,
  output logic [NCH*PD_W-1:0]     ch_phase_delay,
  output logic [NCH*CT_W-1:0]     ch_charge_time,
  output logic [NCH-1:0]          ch_mask,
  input  logic [NCH-1:0]          ch_fire_complete,
  input  logic [NCH-1:0]          ch_warning,
  output logic                    busy,
  output logic                    done,
  output logic                    fault,
  output logic [NP_W-1:0]         pulse_cnt
);

  seqState_e        state_r;
  seqState_e        nextState_s;
  logic [NP_W-1:0]  count_r;
  logic [PRI_W-1:0] pri_r;
  logic [PRI_W-1:0] gapCnt_r;
  logic             allComplete_s;
  logic             anyWarn_s;
  logic             inBusy_s;
  logic             writable_s;
  logic             lastPulse_s;
  logic             countEvt_s;
  logic             doneEvt_s;
  logic             wdExpired_s;

  assign allComplete_s = &ch_fire_complete;
  assign anyWarn_s     = |ch_warning;
  assign inBusy_s      = (state_r != ST_IDLE) && (state_r != ST_FAULT);
  assign writable_s    = !inBusy_s;
  assign lastPulse_s   = ((pulse_cnt + NP_W'(1)) == count_r);
  // A completion is still counted when abort coincides, but never under a warning.
  assign countEvt_s    = (state_r == ST_WAIT) && allComplete_s && !anyWarn_s;
  assign doneEvt_s     = countEvt_s && lastPulse_s && !abort;

  fire_table_regs #(
    .NCH  (NCH),
    .PD_W (PD_W),
    .CT_W (CT_W)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrEn       (cfg_wr && writable_s),
    .wrCh       (cfg_ch),
    .wrPd       (cfg_pd),
    .wrCt       (cfg_ct),
    .wrMask     (cfg_mask),
    .phaseDelay (ch_phase_delay),
    .chargeTime (ch_charge_time),
    .mask       (ch_mask)
  );

`ifdef FIRE_WATCHDOG_EN
  localparam int WD_W = ((PD_W > CT_W) ? PD_W : CT_W) + 2;
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(fireWdLimit(PD_W, CT_W));
  logic [WD_W-1:0] wdCnt_r;

  // Counts cycles spent in the current WAIT visit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdCnt_r <= {WD_W{1'b0}};
    end else if (state_r != ST_WAIT) begin
      wdCnt_r <= {WD_W{1'b0}};
    end else begin
      wdCnt_r <= wdCnt_r + WD_W'(1);
    end
  end

  assign wdExpired_s = (state_r == ST_WAIT) && (wdCnt_r == WD_LIM);
`else
  assign wdExpired_s = 1'b0;
`endif

  // Next-state logic; warning outranks abort, which outranks normal flow.
  always_comb begin
    nextState_s = state_r;
    if (inBusy_s && anyWarn_s) begin
      nextState_s = ST_FAULT;
    end else if (inBusy_s && abort) begin
      nextState_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  if (start) nextState_s = ST_ARM1; else nextState_s = ST_IDLE;
        ST_ARM1:  nextState_s = ST_ARM2;
        ST_ARM2:  nextState_s = ST_FIRE;
        ST_FIRE:  nextState_s = ST_WAIT;
        ST_WAIT: begin
          if (allComplete_s) begin
            if (lastPulse_s) nextState_s = ST_IDLE; else nextState_s = ST_GAP;
          end else if (wdExpired_s) begin
            nextState_s = ST_FAULT;
          end else begin
            nextState_s = ST_WAIT;
          end
        end
        // GAP lasts pri+1 cycles so the fire-to-fire period is WAIT + pri + 4.
        ST_GAP:   if (gapCnt_r == pri_r) nextState_s = ST_ARM1; else nextState_s = ST_GAP;
        ST_FAULT: if (clear_fault) nextState_s = ST_IDLE; else nextState_s = ST_FAULT;
        default:  nextState_s = ST_IDLE;
      endcase
    end
  end

  // State register with outputs decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      ch_rst    <= 1'b1;
      ch_mark   <= 1'b0;
      ch_go     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      cfg_rej   <= 1'b0;
      pulse_cnt <= {NP_W{1'b0}};
      count_r   <= {NP_W{1'b0}};
      pri_r     <= {PRI_W{1'b0}};
      gapCnt_r  <= {PRI_W{1'b0}};
    end else begin
      state_r <= nextState_s;
      ch_rst  <= (nextState_s == ST_IDLE) || (nextState_s == ST_GAP);
      ch_mark <= (nextState_s inside {ST_ARM1, ST_ARM2, ST_FIRE});
      ch_go   <= (nextState_s == ST_FIRE);
      busy    <= (nextState_s != ST_IDLE) && (nextState_s != ST_FAULT);
      fault   <= (nextState_s == ST_FAULT);
      done    <= doneEvt_s;
      cfg_rej <= cfg_wr && !writable_s;
      if ((state_r == ST_IDLE) && start) begin
        count_r   <= (num_pulses == {NP_W{1'b0}}) ? NP_W'(1) : num_pulses;
        pri_r     <= pri;
        pulse_cnt <= {NP_W{1'b0}};
      end else if (countEvt_s) begin
        pulse_cnt <= pulse_cnt + NP_W'(1);
      end
      gapCnt_r <= (state_r == ST_GAP) ? (gapCnt_r + PRI_W'(1)) : {PRI_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_transducer_fire_sequencer.sv
// Directed self-checking bench for transducer_fire_sequencer (default widths).
module tb_transducer_fire_sequencer;

  localparam int WD_LIMIT = 66056;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_wr = 1'b0;
  logic [2:0]   cfg_ch = 3'd0;
  logic [15:0]  cfg_pd = 16'd0;
  logic [8:0]   cfg_ct = 9'd0;
  logic         cfg_mask = 1'b0;
  logic         cfg_rej;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         clear_fault = 1'b0;
  logic [15:0]  num_pulses = 16'd0;
  logic [23:0]  pri = 24'd0;
  logic         ch_rst, ch_mark, ch_go;
  logic [127:0] ch_phase_delay;
  logic [71:0]  ch_charge_time;
  logic [7:0]   ch_mask;
  logic [7:0]   ch_fire_complete = 8'h00;
  logic [7:0]   ch_warning = 8'h00;
  logic         busy, done, fault;
  logic [15:0]  pulse_cnt;

  int checks = 0;
  int errors = 0;

  int goCyc[$];
  int doneCyc[$];
  logic [63:0] markHist, goHist, rstHist, busyHist;

  transducer_fire_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_pd(cfg_pd),
    .cfg_ct(cfg_ct), .cfg_mask(cfg_mask), .cfg_rej(cfg_rej), .start(start),
    .abort(abort), .clear_fault(clear_fault), .num_pulses(num_pulses), .pri(pri),
    .ch_rst(ch_rst), .ch_mark(ch_mark), .ch_go(ch_go),
    .ch_phase_delay(ch_phase_delay), .ch_charge_time(ch_charge_time), .ch_mask(ch_mask),
    .ch_fire_complete(ch_fire_complete), .ch_warning(ch_warning),
    .busy(busy), .done(done), .fault(fault), .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [2:0] ch, input logic [15:0] pd, input logic [8:0] ct, input logic m);
    cfg_wr = 1'b1; cfg_ch = ch; cfg_pd = pd; cfg_ct = ct; cfg_mask = m;
    tick();
    cfg_wr = 1'b0;
  endtask

  // Starts a burst and plays the channels: all complete W cycles after each go.
  task automatic run_seq(input logic [15:0] np, input logic [23:0] pr, input int w,
                         input int abortAt, input int cycles);
    int lastGo;
    goCyc.delete(); doneCyc.delete();
    markHist = 64'd0; goHist = 64'd0; rstHist = 64'd0; busyHist = 64'd0;
    lastGo = -1000;
    num_pulses = np; pri = pr; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= cycles; k++) begin
      if (ch_go === 1'b1) begin goCyc.push_back(k); lastGo = k; end
      if (done === 1'b1) doneCyc.push_back(k);
      if (k < 64) begin
        markHist[k] = ch_mark; goHist[k] = ch_go; rstHist[k] = ch_rst; busyHist[k] = busy;
      end
      ch_fire_complete = (k == lastGo + w) ? 8'hFF : 8'h00;
      abort = (k == abortAt);
      tick();
    end
    ch_fire_complete = 8'h00;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if ({ch_rst, ch_mark, ch_go, busy, done, fault, cfg_rej} !== 7'b1000000) begin
      errors++; $display("FAIL reset_ctrl got %b want 1000000", {ch_rst, ch_mark, ch_go, busy, done, fault, cfg_rej}); end
    checks++; if (pulse_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", pulse_cnt); end
    checks++; if ({ch_phase_delay, ch_charge_time, ch_mask} !== 208'd0) begin
      errors++; $display("FAIL reset_table got nonzero want 0"); end
    rst_n = 1'b1;
    tick();
    checks++; if ({ch_rst, busy, fault} !== 3'b100) begin
      errors++; $display("FAIL reset_idle got %b want 100", {ch_rst, busy, fault}); end
  endtask

  task automatic test_table();
    write_cfg(3'd0, 16'd3, 9'd5, 1'b1);
    for (int i = 1; i < 8; i++) write_cfg(3'(i), 16'd0, 9'd1, 1'b0);
    checks++; if (ch_phase_delay !== 128'd3) begin
      errors++; $display("FAIL table_pd got %h want 3", ch_phase_delay); end
    checks++; if (ch_charge_time !== {{7{9'd1}}, 9'd5}) begin
      errors++; $display("FAIL table_ct got %h want %h", ch_charge_time, {{7{9'd1}}, 9'd5}); end
    checks++; if (ch_mask !== 8'h01) begin errors++; $display("FAIL table_mask got %h want 01", ch_mask); end
  endtask

  task automatic test_single_fire();
    run_seq(16'd1, 24'd0, 10, -1, 20);
    checks++; if (markHist !== 64'h0E) begin errors++; $display("FAIL single_mark got %h want 0e", markHist); end
    checks++; if (goHist !== 64'h08) begin errors++; $display("FAIL single_go got %h want 08", goHist); end
    checks++; if (rstHist !== 64'h1FC000) begin errors++; $display("FAIL single_rst got %h want 1fc000", rstHist); end
    checks++; if (doneCyc.size() !== 1 || doneCyc[0] !== 14) begin
      errors++; $display("FAIL single_done got n=%0d at %0d want n=1 at 14", doneCyc.size(), doneCyc[0]); end
    checks++; if (pulse_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", pulse_cnt); end
  endtask

  task automatic test_zero_pulses();
    run_seq(16'd0, 24'd0, 2, -1, 20);
    checks++; if (goCyc.size() !== 1) begin errors++; $display("FAIL zero_go got %0d want 1", goCyc.size()); end
    checks++; if (doneCyc.size() !== 1 || doneCyc[0] !== 6) begin
      errors++; $display("FAIL zero_done got n=%0d at %0d want n=1 at 6", doneCyc.size(), doneCyc[0]); end
  endtask

  task automatic test_burst();
    run_seq(16'd3, 24'd10, 6, -1, 70);
    checks++; if (goCyc.size() !== 3) begin errors++; $display("FAIL burst_fires got %0d want 3", goCyc.size()); end
    checks++; if (goCyc[0] !== 3 || goCyc[1] !== 23 || goCyc[2] !== 43) begin
      errors++; $display("FAIL burst_spacing got %0d %0d %0d want 3 23 43", goCyc[0], goCyc[1], goCyc[2]); end
    checks++; if (doneCyc.size() !== 1 || doneCyc[0] !== 50) begin
      errors++; $display("FAIL burst_done got n=%0d at %0d want n=1 at 50", doneCyc.size(), doneCyc[0]); end
    checks++; if (pulse_cnt !== 16'd3) begin errors++; $display("FAIL burst_cnt got %0d want 3", pulse_cnt); end
  endtask

  task automatic test_abort();
    run_seq(16'd4, 24'd10, 3, 10, 30);
    checks++; if (busyHist[11:9] !== 3'b011 || rstHist[11] !== 1'b1) begin
      errors++; $display("FAIL abort_gap_idle got busy=%b rst=%b want 011 1", busyHist[11:9], rstHist[11]); end
    checks++; if (doneCyc.size() !== 0 || goCyc.size() !== 1) begin
      errors++; $display("FAIL abort_gap_done got done=%0d go=%0d want 0 1", doneCyc.size(), goCyc.size()); end
    checks++; if (pulse_cnt !== 16'd1) begin errors++; $display("FAIL abort_gap_cnt got %0d want 1", pulse_cnt); end
    run_seq(16'd1, 24'd0, 3, 6, 12);
    checks++; if (doneCyc.size() !== 0 || pulse_cnt !== 16'd1 || busyHist[7] !== 1'b0) begin
      errors++; $display("FAIL abort_done_cnt got done=%0d cnt=%0d busy=%b want 0 1 0",
                         doneCyc.size(), pulse_cnt, busyHist[7]); end
  endtask

  task automatic test_warning();
    ch_warning = 8'h04; tick(); ch_warning = 8'h00;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL warn_idle got fault=%b want 0", fault); end
    num_pulses = 16'd1; pri = 24'd0; start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    checks++; if ({busy, ch_mark, ch_go} !== 3'b100) begin
      errors++; $display("FAIL warn_in_wait got %b want 100", {busy, ch_mark, ch_go}); end
    ch_warning = 8'h04; tick(); ch_warning = 8'h00;
    checks++; if ({fault, busy, ch_rst, ch_mark} !== 4'b1000) begin
      errors++; $display("FAIL warn_fault got %b want 1000", {fault, busy, ch_rst, ch_mark}); end
    write_cfg(3'd7, 16'h0007, 9'd1, 1'b0);
    checks++; if (cfg_rej !== 1'b0 || ch_phase_delay[127:112] !== 16'h0007 || fault !== 1'b1) begin
      errors++; $display("FAIL fault_write got rej=%b pd=%h fault=%b want 0 0007 1",
                         cfg_rej, ch_phase_delay[127:112], fault); end
    clear_fault = 1'b1; tick(); clear_fault = 1'b0;
    checks++; if ({ch_rst, fault, busy} !== 3'b100) begin
      errors++; $display("FAIL clear_fault got %b want 100", {ch_rst, fault, busy}); end
    start = 1'b1; tick(); start = 1'b0; tick();
    abort = 1'b1; ch_warning = 8'h80; tick(); abort = 1'b0; ch_warning = 8'h00;
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL warn_over_abort got fault=%b want 1", fault); end
    clear_fault = 1'b1; tick(); clear_fault = 1'b0;
  endtask

  task automatic test_cfg_reject();
    num_pulses = 16'd1; pri = 24'd0; start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    write_cfg(3'd1, 16'hBEEF, 9'h1AA, 1'b1);
    checks++; if (cfg_rej !== 1'b1 || ch_phase_delay[31:16] !== 16'h0000 || ch_mask !== 8'h01) begin
      errors++; $display("FAIL rej_pulse got rej=%b pd=%h mask=%h want 1 0000 01",
                         cfg_rej, ch_phase_delay[31:16], ch_mask); end
    tick();
    checks++; if (cfg_rej !== 1'b0) begin errors++; $display("FAIL rej_one_cycle got %b want 0", cfg_rej); end
    abort = 1'b1; tick(); abort = 1'b0;
    write_cfg(3'd1, 16'hBEEF, 9'h1AA, 1'b1);
    checks++; if (cfg_rej !== 1'b0 || ch_phase_delay[31:16] !== 16'hBEEF ||
                  ch_charge_time[17:9] !== 9'h1AA || ch_mask !== 8'h03) begin
      errors++; $display("FAIL idle_write got rej=%b pd=%h ct=%h mask=%h want 0 beef 1aa 03",
                         cfg_rej, ch_phase_delay[31:16], ch_charge_time[17:9], ch_mask); end
  endtask

  task automatic test_hold_low();
    ch_fire_complete = 8'hDF;
    num_pulses = 16'd1; pri = 24'd0; start = 1'b1; tick(); start = 1'b0;
`ifdef FIRE_WATCHDOG_EN
    for (int k = 1; k < WD_LIMIT + 4; k++) tick();
    checks++; if ({fault, busy} !== 2'b01) begin
      errors++; $display("FAIL wd_before got %b want 01", {fault, busy}); end
    tick();
    checks++; if ({fault, busy} !== 2'b10) begin
      errors++; $display("FAIL wd_expire got %b want 10", {fault, busy}); end
    clear_fault = 1'b1; tick(); clear_fault = 1'b0;
`else
    for (int k = 1; k < 304; k++) tick();
    checks++; if ({fault, busy, ch_rst, ch_mark} !== 4'b0100) begin
      errors++; $display("FAIL hold_wait got %b want 0100", {fault, busy, ch_rst, ch_mark}); end
    abort = 1'b1; tick(); abort = 1'b0;
`endif
    ch_fire_complete = 8'h00;
    checks++; if ({busy, ch_rst} !== 2'b01) begin errors++; $display("FAIL hold_exit got %b want 01", {busy, ch_rst}); end
  endtask

  initial begin
    test_reset();
    test_table();
    test_single_fire();
    test_zero_pulses();
    test_burst();
    test_abort();
    test_warning();
    test_cfg_reject();
    test_hold_low();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
